seq101_framer_tx: RTL and testbench

SEQ101_FRAMER_TX -- requirements
Module: seq101_framer_tx

---
 rtl/seq101_framer_tx.sv | 121 ++++++++++++
 tb/tb_seq101_framer_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq101_framer_tx.sv
// Serial framer: preamble 1,0,1, MSB-first payload with 0-stuffing so 1,0,1 never recurs, then 2 guard zeros.
// First bit one cycle after start is accepted; start is ignored (no backpressure) while busy.
module seq101_framer_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              x,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, PRE, DATA, STUFF, GUARD} state_t;

  localparam int CW = $clog2(DATA_W + 4);
  localparam logic [CW-1:0] LAST = CW'(DATA_W);

  state_t            state, nstate;
  logic [CW-1:0]     cnt, ncnt;
  logic [DATA_W-1:0] sreg, nsreg;
  logic [1:0]        hist, nhist;
  logic              nx, nbusy, ndone;
  logic              next_bit;
  logic              need_stuff;
  logic [CW-1:0]     sent;

  // hist already includes the bit on the line this cycle
  assign need_stuff = (hist == 2'b10) && sreg[DATA_W-1];
  assign sent       = (state == PRE) ? '0 : cnt;

  always_comb begin
    nstate   = state;
    ncnt     = cnt;
    nsreg    = sreg;
    nx       = 1'b0;
    nbusy    = 1'b0;
    ndone    = 1'b0;
    next_bit = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          nstate = PRE;
          ncnt   = '0;
          nsreg  = data;
          nx     = 1'b1;
          nbusy  = 1'b1;
        end
      end
      PRE: begin
        if (cnt != CW'(2)) begin
          ncnt  = cnt + CW'(1);
          nx    = (cnt == CW'(1));
          nbusy = 1'b1;
        end else begin
          next_bit = 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          nstate = GUARD;
          ncnt   = '0;
          ndone  = 1'b1;
          nbusy  = 1'b1;
        end else begin
          next_bit = 1'b1;
        end
      end
      STUFF: next_bit = 1'b1;
      GUARD: begin
        if (cnt == '0) begin
          ncnt  = CW'(1);
          nbusy = 1'b1;
        end else begin
          nstate = IDLE;
          ncnt   = '0;
        end
      end
      default: nstate = IDLE;
    endcase

    // A stuffed 0 leaves the pending payload bit in place for the next cycle
    if (next_bit) begin
      nbusy = 1'b1;
      if (need_stuff) begin
        nstate = STUFF;
        nx     = 1'b0;
      end else begin
        nstate = DATA;
        nx     = sreg[DATA_W-1];
        nsreg  = sreg << 1;
        ncnt   = sent + CW'(1);
      end
    end

    nhist = {hist[0], nx};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      hist  <= 2'b00;
      x     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
      sreg  <= nsreg;
      hist  <= nhist;
      x     <= nx;
      busy  <= nbusy;
      done  <= ndone;
    end
  end

endmodule

// File: tb/tb_seq101_framer_tx.sv
// Directed bench for seq101_framer_tx: table of frames with hand-computed line images plus corner sequences.
module tb_seq101_framer_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       x, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq101_framer_tx #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .data  (data),
    .x     (x),
    .busy  (busy),
    .done  (done)
  );

  // line = every bit on x while busy, first bit in the MSB of a len-bit value
  typedef struct {
    logic [7:0]  d;
    logic [63:0] line;
    int          len;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [63:0] line, input int len, input string tag);
    logic [63:0] got;
    int n, done_cnt, done_at, pat;
    @(negedge clk);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
    data  = ~d;
    n = 0; got = '0; done_cnt = 0; done_at = -1;
    while (busy && n < 64) begin
      got = {got[62:0], x};
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      // stray requests mid-payload and in the last guard cycle must be ignored
      start = (n == 4) || (n == len - 1);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    pat = 0;
    for (int i = 1; i + 2 < n && i + 2 < 64; i++)
      if (got[n-1-i] && !got[n-2-i] && got[n-3-i]) pat++;
    check({tag, " busy_len"}, 64'(n), 64'(len));
    check({tag, " line"}, got, line);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " done_pos"}, 64'(done_at), 64'(len - 2));
    check({tag, " no_101_after_pre"}, 64'(pat), 64'd0);
  endtask

  initial begin
    int ex, eb, ed, stray;
    logic [13:0] fr;

    vecs[0] = '{8'h00, 64'b1010000000000,     13};
    vecs[1] = '{8'hFF, 64'b1011111111100,     13};
    vecs[2] = '{8'hA5, 64'b101100100100100,   15};
    vecs[3] = '{8'h55, 64'b10100100100100100, 17};
    vecs[4] = '{8'h2A, 64'b101001001001000,   15};
    vecs[5] = '{8'hC3, 64'b1011100001100,     13};

    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset x", 64'(x), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].d, vecs[v].line, vecs[v].len, $sformatf("frame_%02h", vecs[v].d));

    // start held high: 13 busy cycles, one idle cycle, next frame
    fr = 14'b10100000000000;
    ex = 0; eb = 0; ed = 0;
    @(negedge clk);
    start = 1'b1;
    data  = 8'h00;
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      if (x !== fr[13 - (i % 14)]) ex++;
      if (busy !== ((i % 14) < 13)) eb++;
      if (done !== ((i % 14) == 11)) ed++;
    end
    start = 1'b0;
    check("held_start x_errs", 64'(ex), 64'd0);
    check("held_start busy_errs", 64'(eb), 64'd0);
    check("held_start done_errs", 64'(ed), 64'd0);
    repeat (16) @(negedge clk);

    // reset during DATA aborts with no guard and no done
    start = 1'b1;
    data  = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_reset pre busy", 64'(busy), 64'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("mid_reset x", 64'(x), 64'd0);
    check("mid_reset busy", 64'(busy), 64'd0);
    check("mid_reset done", 64'(done), 64'd0);
    @(negedge clk);
    check("reset_ignores_start busy", 64'(busy), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || x) stray++;
    end
    check("after_reset quiet", 64'(stray), 64'd0);
    run_frame(8'hA5, 64'b101100100100100, 15, "post_reset_A5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
